// File: rtl/alu_exec_if.sv
// alu_exec_if: operand/result handshake bundle for the execute-stage ALU.
// Carries the input handshake (in_valid/in_ready + operands), the output
// handshake (out_valid/out_ready + head result and flags).
// Optional: ALU_EXT_FLAGS_EN adds Negative/Carry/Overflow to the bundle.
//
// Handshake rule (both directions): a transfer happens on a rising clock
// edge where valid && ready are both 1. The producer holds its payload
// stable while valid=1 and ready=0, and ready never depends on valid.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Illegal;
`ifdef ALU_EXT_FLAGS_EN
  logic             Negative;
  logic             Carry;
  logic             Overflow;
`endif

  // Upstream/downstream side (operand fetch and writeback as one agent)
  modport master (
    output in_valid, ALUControl, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, Illegal
`ifdef ALU_EXT_FLAGS_EN
    , input Negative, Carry, Overflow
`endif
  );

  // ALU side
  modport slave (
    input  in_valid, ALUControl, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero, Illegal
`ifdef ALU_EXT_FLAGS_EN
    , output Negative, Carry, Overflow
`endif
  );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: handshaked RISC-V execute-stage ALU with a 2-entry result buffer.
// Ops: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT; other codes are flagged
// Illegal (result 0, Zero 1) but still flow through the buffer.
// Optional: ALU_EXT_FLAGS_EN stores/presents Negative, Carry, Overflow.
// The buffer head always lives in entry 0; entry 1 holds the second result
// while FULL and shifts into entry 0 on the pop that leaves FULL.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  alu_exec_if.slave   bus,
  output logic [1:0]  state_dbg_o
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
`ifdef ALU_EXT_FLAGS_EN
    logic             negative;
    logic             carry;
    logic             overflow;
`endif
  } entry_t;

  occ_e   state_q, state_d;
  entry_t entry0_q, entry0_d;
  entry_t entry1_q, entry1_d;
  entry_t new_entry;

  logic push, pop;
  logic in_ready, out_valid;
  logic wr0, wr1, shift;

  // ---------------------------------------------------------------------
  // Datapath: one shared adder serves ADD, SUB and SLT
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic             is_add, is_sub, is_slt, is_logic, is_illegal;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;
  logic             slt_bit;
  logic [WIDTH-1:0] res;
`ifdef ALU_EXT_FLAGS_EN
  logic [WIDTH:0]   add_full;
  logic             add_cout;
`endif

  // Decode the op and select the adder's B operand / carry-in
  always_comb begin
    b_eff      = bus.SrcB;
    cin        = 1'b0;
    is_add     = 1'b0;
    is_sub     = 1'b0;
    is_slt     = 1'b0;
    is_logic   = 1'b0;
    is_illegal = 1'b0;
    case (bus.ALUControl)
      OP_ADD: is_add = 1'b1;
      OP_SUB: begin
        is_sub = 1'b1;
        b_eff  = ~bus.SrcB;
        cin    = 1'b1;
      end
      OP_AND: is_logic = 1'b1;
      OP_OR:  is_logic = 1'b1;
      OP_SLT: begin
        is_slt = 1'b1;
        b_eff  = ~bus.SrcB;
        cin    = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

`ifdef ALU_EXT_FLAGS_EN
  assign add_full = {1'b0, bus.SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  assign add_sum  = add_full[WIDTH-1:0];
  assign add_cout = add_full[WIDTH];
`else
  assign add_sum  = bus.SrcA + b_eff + {{(WIDTH-1){1'b0}}, cin};
`endif

  // Signed overflow: operands agree in sign but the sum does not
  assign add_ovf = (bus.SrcA[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != bus.SrcA[WIDTH-1]);
  // Signed less-than from the subtract: sign corrected by overflow
  assign slt_bit = add_sum[WIDTH-1] ^ add_ovf;

  // Select the result for the decoded op; illegal codes give 0
  always_comb begin
    res = '0;
    if (is_add || is_sub) begin
      res = add_sum;
    end else if (is_slt) begin
      res = {{(WIDTH-1){1'b0}}, slt_bit};
    end else if (is_logic) begin
      res = (bus.ALUControl == OP_AND) ? (bus.SrcA & bus.SrcB)
                                       : (bus.SrcA | bus.SrcB);
    end
  end

  // Assemble the entry that is written into the buffer on a push
  always_comb begin
    new_entry         = '0;
    new_entry.result  = res;
    new_entry.zero    = (res == '0);
    new_entry.illegal = is_illegal;
`ifdef ALU_EXT_FLAGS_EN
    new_entry.negative = res[WIDTH-1];
    new_entry.carry    = (is_add || is_sub || is_slt) ? add_cout : 1'b0;
    new_entry.overflow = (is_add || is_sub) ? add_ovf : 1'b0;
`endif
  end

  // ---------------------------------------------------------------------
  // Occupancy FSM and buffer control
  // ---------------------------------------------------------------------
  assign in_ready = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push     = bus.in_valid && in_ready;
  assign pop      = out_valid && bus.out_ready;

  // Occupancy state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and which buffer slot is written/shifted this cycle
  always_comb begin
    state_d = state_q;
    wr0     = 1'b0;
    wr1     = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          wr0     = 1'b1;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          wr0 = 1'b1;
        end else if (push) begin
          state_d = ST_FULL;
          wr1     = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          shift   = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Next contents of the two buffer slots
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    if (shift) entry0_d = entry1_q;
    if (wr0)   entry0_d = new_entry;
    if (wr1)   entry1_d = new_entry;
  end

  // Buffer storage; reset clears it so outputs read 0 out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: head comes straight from entry 0 storage
  // ---------------------------------------------------------------------
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.ALUResult = entry0_q.result;
  assign bus.Zero      = entry0_q.zero;
  assign bus.Illegal   = entry0_q.illegal;
`ifdef ALU_EXT_FLAGS_EN
  assign bus.Negative  = entry0_q.negative;
  assign bus.Carry     = entry0_q.carry;
  assign bus.Overflow  = entry0_q.overflow;
`endif
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed-vector bench for alu_exec. Driver tasks push the
// hand-computed expected entry when an op is accepted; an independent
// monitor pops and compares whenever the DUT hands a result downstream.
// Expected word layout: {Overflow, Carry, Negative, Illegal, Zero, Result}.
module tb_alu_exec;
  localparam int W  = 32;
  localparam int EW = W + 5;
  localparam int WAIT_BOUND = 20;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] SLT = 3'b101;

  logic       clk;
  logic       reset_n;
  logic [1:0] state_dbg;
  int         tests_run;
  int         tests_failed;
  int         cyc;

  logic [EW-1:0] exp_q[$];
  int            pop_cyc_q[$];

  alu_exec_if #(.WIDTH(W)) bus ();

  alu_exec #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .state_dbg_o(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, exp_q size %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic [W-1:0] r, input logic z, input logic ill,
                                        input logic n, input logic c, input logic v);
`ifdef ALU_EXT_FLAGS_EN
    return {v, c, n, ill, z, r};
`else
    return {3'b000, ill, z, r};
`endif
  endfunction

  // Drive one op and wait (bounded) for acceptance; called just after a posedge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [EW-1:0] expv, output int waits);
    bit done;
    bus.in_valid   = 1'b1;
    bus.ALUControl = op;
    bus.SrcA       = a;
    bus.SrcB       = b;
    waits = 0;
    done  = 0;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(expv);
        @(posedge clk); #1;
        done = 1;
      end else begin
        waits++;
        if (waits > WAIT_BOUND) begin
          tests_run++;
          tests_failed++;
          $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", waits);
          done = 1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.ALUControl = 3'b000;
    bus.SrcA       = '0;
    bus.SrcB       = '0;
  endtask

  // Wait (bounded) until every expected result has been consumed
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < WAIT_BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] expv;
    if (reset_n && bus.out_valid && bus.out_ready) begin
`ifdef ALU_EXT_FLAGS_EN
      act = {bus.Overflow, bus.Carry, bus.Negative, bus.Illegal, bus.Zero, bus.ALUResult};
`else
      act = {3'b000, bus.Illegal, bus.Zero, bus.ALUResult};
`endif
      pop_cyc_q.push_back(cyc);
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_output: got 0x%0h with no result expected", act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          tests_failed++;
          $display("FAIL result_entry: got 0x%0h, expected 0x%0h (t=%0t)", act, expv, $time);
        end
      end
    end
  end

  // ---------------- directed sequences ----------------
  logic [2:0]  b2b_op [8];
  logic [31:0] b2b_a  [8];
  logic [31:0] b2b_b  [8];
  logic [EW-1:0] b2b_e [8];

  initial begin
    int w;
    int wsum;
    int c0;
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    reset_n      = 1'b0;
    bus.out_ready = 1'b0;
    idle();

    // back-to-back table: op, A, B, expected {ovf,carry,neg,ill,zero,res}
    b2b_op[0] = ADD; b2b_a[0] = 32'h1;        b2b_b[0] = 32'h1;        b2b_e[0] = ent(32'h2,        0, 0, 0, 0, 0);
    b2b_op[1] = SUB; b2b_a[1] = 32'hA;        b2b_b[1] = 32'h4;        b2b_e[1] = ent(32'h6,        0, 0, 0, 1, 0);
    b2b_op[2] = AND; b2b_a[2] = 32'hFF;       b2b_b[2] = 32'h0F;       b2b_e[2] = ent(32'h0F,       0, 0, 0, 0, 0);
    b2b_op[3] = OR;  b2b_a[3] = 32'hF0;       b2b_b[3] = 32'h0F;       b2b_e[3] = ent(32'hFF,       0, 0, 0, 0, 0);
    b2b_op[4] = SLT; b2b_a[4] = 32'h1;        b2b_b[4] = 32'h2;        b2b_e[4] = ent(32'h1,        0, 0, 0, 0, 0);
    b2b_op[5] = SLT; b2b_a[5] = 32'h5;        b2b_b[5] = 32'hFFFFFFFD; b2b_e[5] = ent(32'h0,        1, 0, 0, 0, 0);
    b2b_op[6] = ADD; b2b_a[6] = 32'hFFFFFFFF; b2b_b[6] = 32'h1;        b2b_e[6] = ent(32'h0,        1, 0, 0, 1, 0);
    b2b_op[7] = SUB; b2b_a[7] = 32'h80000000; b2b_b[7] = 32'h1;        b2b_e[7] = ent(32'h7FFFFFFF, 0, 0, 0, 1, 1);

    // reset state
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready",  bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_result",    bus.ALUResult, 0);
    check("reset_zero",      bus.Zero, 0);
    check("reset_illegal",   bus.Illegal, 0);
    check("reset_state",     state_dbg, 0);
    @(posedge clk); #1;

    // single ADD with one-cycle latency
    bus.out_ready = 1'b1;
    issue(ADD, 32'h5, 32'h3, ent(32'h8, 0, 0, 0, 0, 0), w);
    idle();
    @(negedge clk);
    check("latency_out_valid", bus.out_valid, 1);
    check("latency_result",    bus.ALUResult, 32'h8);
    check("latency_zero",      bus.Zero, 0);
    @(posedge clk); #1;
    drain("drain_add");

    // SUB to zero, SLT, signed overflow, borrow
    issue(SUB, 32'h7,        32'h7, ent(32'h0,        1, 0, 0, 1, 0), w);
    issue(SLT, 32'hFFFFFFFF, 32'h1, ent(32'h1,        0, 0, 0, 1, 0), w);
    issue(ADD, 32'h7FFFFFFF, 32'h1, ent(32'h80000000, 0, 0, 1, 0, 1), w);
    issue(SUB, 32'h3,        32'h5, ent(32'hFFFFFFFE, 0, 0, 1, 0, 0), w);
    idle();
    drain("drain_arith");

    // stall with out_ready low: two accepted, third waits for the bubble
    bus.out_ready = 1'b0;
    issue(ADD, 32'h1,        32'h2,        ent(32'h3,        0, 0, 0, 0, 0), w);
    issue(AND, 32'hF0F000FF, 32'h0FF00F0F, ent(32'h00F0000F, 0, 0, 0, 0, 0), w);
    bus.in_valid = 1'b1; bus.ALUControl = OR; bus.SrcA = 32'h12000034; bus.SrcB = 32'h00005600;
    @(negedge clk);
    check("full_in_ready",  bus.in_ready, 0);
    check("full_state",     state_dbg, 2);
    check("full_head_hold", bus.ALUResult, 32'h3);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_head_stable", bus.ALUResult, 32'h3);
    check("full_still_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue(OR, 32'h12000034, 32'h00005600, ent(32'h12005634, 0, 0, 0, 0, 0), w);
    check("bubble_wait_cycles", w, 1);
    idle();
    drain("drain_stall");

    // illegal codes, then a legal op clears Illegal
    issue(3'b110, 32'h1234,     32'h5678,     ent(32'h0, 1, 1, 0, 0, 0), w);
    issue(SUB,    32'hA,        32'h3,        ent(32'h7, 0, 0, 0, 1, 0), w);
    issue(3'b100, 32'h1,        32'h1,        ent(32'h0, 1, 1, 0, 0, 0), w);
    issue(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, ent(32'h0, 1, 1, 0, 0, 0), w);
    idle();
    drain("drain_illegal");

    // eight back-to-back ops with out_ready held high
    wsum = 0;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      issue(b2b_op[i], b2b_a[i], b2b_b[i], b2b_e[i], w);
      wsum += w;
    end
    idle();
    check("b2b_no_stall", wsum, 0);
    check("b2b_accept_cycles", cyc - c0, 8);
    drain("drain_b2b");
    check("b2b_consecutive_pops",
          pop_cyc_q[pop_cyc_q.size()-1] - pop_cyc_q[pop_cyc_q.size()-8], 7);

    // asynchronous reset with a full buffer
    bus.out_ready = 1'b0;
    issue(ADD, 32'h10, 32'h20, ent(32'h30, 0, 0, 0, 0, 0), w);
    issue(ADD, 32'h40, 32'h50, ent(32'h90, 0, 0, 0, 0, 0), w);
    idle();
    @(negedge clk);
    check("pre_reset_full", state_dbg, 2);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_out_valid", bus.out_valid, 0);
    check("async_reset_result",    bus.ALUResult, 0);
    check("async_reset_in_ready",  bus.in_ready, 1);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_no_stale", bus.out_valid, 0);
    end
    @(posedge clk); #1;
    issue(ADD, 32'h100, 32'h23, ent(32'h123, 0, 0, 0, 0, 0), w);
    idle();
    drain("drain_post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
